ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand bypass and hazard detection, directly upstream of the ALU.

---
 rtl/ex_operand_stage_pkg.sv | 34 +++
 rtl/ex_operand_stage_fwd_unit.sv | 31 +++
 rtl/ex_operand_stage.sv | 183 ++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcodes, control bundle, bypass selects.
// The optional bypass network is enabled by defining BYPASS_EN.
package ex_operand_stage_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RADDR_W_DEF = 3;
    localparam int OP_W_DEF    = 4;

    localparam logic [3:0] A_AND = 4'h0;
    localparam logic [3:0] A_OR  = 4'h1;
    localparam logic [3:0] A_XOR = 4'h2;
    localparam logic [3:0] A_ADD = 4'h3;
    localparam logic [3:0] A_SUB = 4'h4;
    localparam logic [3:0] A_SLL = 4'h5;
    localparam logic [3:0] A_SRL = 4'h6;
    localparam logic [3:0] A_SRA = 4'h7;

    // Control fields that a bubble clears; every other latched field is plain data.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0};

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// Bypass source selection for one operand: picks EX/MEM, then MEM/WB, else the latched regfile data.
import ex_operand_stage_pkg::*;

module fwd_unit #(
    parameter int RADDR_W = 3
) (
    input  logic               en,
    input  logic [RADDR_W-1:0] rs,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               exmem_regwrite,
    input  logic               exmem_memread,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               memwb_regwrite,
    output logic [1:0]         sel
);

    // A load still in EX/MEM has no data yet, so it is never a bypass source there.
    always_comb begin
        sel = FWD_RF;
        if (!en) begin
            sel = FWD_RF;
        end else if (exmem_regwrite && !exmem_memread && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand bypass and hazard stall generation feeding the ALU.
// Define BYPASS_EN for forwarding with load-use-only stalls; otherwise every RAW dependency stalls.
import ex_operand_stage_pkg::*;

module ex_operand_stage #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    input  logic [OP_W-1:0]    id_aluop_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic [RADDR_W-1:0] id_rd_i,
    input  logic [DATA_W-1:0]  id_rdata1_i,
    input  logic [DATA_W-1:0]  id_rdata2_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic               id_use_imm_i,
    input  logic               id_regwrite_i,
    input  logic               id_memread_i,
    input  logic               id_memwrite_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_regwrite_i,
    input  logic               exmem_memread_i,
    input  logic [DATA_W-1:0]  exmem_result_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_regwrite_i,
    input  logic [DATA_W-1:0]  memwb_data_i,
    input  logic               flush_i,
    input  logic               hold_i,
    output logic               stall_o,
    output logic               ex_valid_o,
    output logic [OP_W-1:0]    ex_aluop_o,
    output logic [DATA_W-1:0]  ex_opa_o,
    output logic [DATA_W-1:0]  ex_opb_o,
    output logic [DATA_W-1:0]  ex_stdata_o,
    output logic [RADDR_W-1:0] ex_rd_o,
    output logic               ex_regwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memwrite_o
);

    ex_ctrl_t           ctrl_r;
    ex_ctrl_t           id_ctrl_s;
    logic [OP_W-1:0]    aluop_r;
    logic [RADDR_W-1:0] rs1_r;
    logic [RADDR_W-1:0] rs2_r;
    logic [RADDR_W-1:0] rd_r;
    logic [DATA_W-1:0]  rdata1_r;
    logic [DATA_W-1:0]  rdata2_r;
    logic [DATA_W-1:0]  imm_r;
    logic               use_imm_r;

    logic               rs2_used_s;
    logic               hazard_raw_s;
    logic               hazard_s;
    logic               fwd_en_s;
    logic [1:0]         sel_a_s;
    logic [1:0]         sel_b_s;
    logic [DATA_W-1:0]  opa_s;
    logic [DATA_W-1:0]  rs2_val_s;

    // Decoded controls only count when ID actually holds an instruction.
    always_comb begin
        id_ctrl_s.valid    = id_valid_i;
        id_ctrl_s.regwrite = id_regwrite_i & id_valid_i;
        id_ctrl_s.memread  = id_memread_i  & id_valid_i;
        id_ctrl_s.memwrite = id_memwrite_i & id_valid_i;
    end

    // rs2 is a real source unless the immediate replaces it; stores always read it as data.
    assign rs2_used_s = ~id_use_imm_i | id_memwrite_i;

`ifdef BYPASS_EN
    assign fwd_en_s = ctrl_r.valid;

    // Only a load in EX cannot be bypassed in time.
    always_comb begin
        hazard_raw_s = id_valid_i & ctrl_r.valid & ctrl_r.memread &
                       ((rd_r == id_rs1_i) | ((rd_r == id_rs2_i) & rs2_used_s));
        hazard_s     = hazard_raw_s & ~flush_i;
    end
`else
    logic ex_hit_s;
    logic mem_hit_s;

    assign fwd_en_s = 1'b0;

    // Without bypass, wait until the producer has reached the write-through regfile.
    always_comb begin
        ex_hit_s     = ctrl_r.valid & ctrl_r.regwrite &
                       ((rd_r == id_rs1_i) | ((rd_r == id_rs2_i) & rs2_used_s));
        mem_hit_s    = exmem_regwrite_i &
                       ((exmem_rd_i == id_rs1_i) | ((exmem_rd_i == id_rs2_i) & rs2_used_s));
        hazard_raw_s = id_valid_i & (ex_hit_s | mem_hit_s);
        hazard_s     = hazard_raw_s & ~flush_i;
    end
`endif

    assign stall_o = hazard_s | hold_i;

    // ID/EX register: flush beats hold, hold freezes, a hazard inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r    <= BUBBLE_CTRL;
            aluop_r   <= OP_W'(A_AND);
            rs1_r     <= {RADDR_W{1'b0}};
            rs2_r     <= {RADDR_W{1'b0}};
            rd_r      <= {RADDR_W{1'b0}};
            rdata1_r  <= {DATA_W{1'b0}};
            rdata2_r  <= {DATA_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
            use_imm_r <= 1'b0;
        end else if (flush_i) begin
            ctrl_r <= BUBBLE_CTRL;
        end else if (hold_i) begin
            ctrl_r <= ctrl_r;
        end else if (hazard_s) begin
            ctrl_r <= BUBBLE_CTRL;
        end else begin
            ctrl_r    <= id_ctrl_s;
            aluop_r   <= id_aluop_i;
            rs1_r     <= id_rs1_i;
            rs2_r     <= id_rs2_i;
            rd_r      <= id_rd_i;
            rdata1_r  <= id_rdata1_i;
            rdata2_r  <= id_rdata2_i;
            imm_r     <= id_imm_i;
            use_imm_r <= id_use_imm_i;
        end
    end

    fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_a (
        .en             (fwd_en_s),
        .rs             (rs1_r),
        .exmem_rd       (exmem_rd_i),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_memread  (exmem_memread_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_regwrite (memwb_regwrite_i),
        .sel            (sel_a_s)
    );

    fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_b (
        .en             (fwd_en_s),
        .rs             (rs2_r),
        .exmem_rd       (exmem_rd_i),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_memread  (exmem_memread_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_regwrite (memwb_regwrite_i),
        .sel            (sel_b_s)
    );

    // Operand muxes sit after the register so forwarded values reach the ALU in the same cycle.
    always_comb begin
        opa_s     = rdata1_r;
        rs2_val_s = rdata2_r;
        case (sel_a_s)
            FWD_EXMEM: opa_s = exmem_result_i;
            FWD_MEMWB: opa_s = memwb_data_i;
            default:   opa_s = rdata1_r;
        endcase
        case (sel_b_s)
            FWD_EXMEM: rs2_val_s = exmem_result_i;
            FWD_MEMWB: rs2_val_s = memwb_data_i;
            default:   rs2_val_s = rdata2_r;
        endcase
    end

    assign ex_valid_o    = ctrl_r.valid;
    assign ex_regwrite_o = ctrl_r.regwrite;
    assign ex_memread_o  = ctrl_r.memread;
    assign ex_memwrite_o = ctrl_r.memwrite;
    assign ex_aluop_o    = aluop_r;
    assign ex_rd_o       = rd_r;
    assign ex_opa_o      = opa_s;
    assign ex_stdata_o   = rs2_val_s;
    assign ex_opb_o      = use_imm_r ? imm_r : rs2_val_s;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and random checks of ex_operand_stage against a behavioural pipeline model.
module tb_ex_operand_stage;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i, id_use_imm_i, id_regwrite_i, id_memread_i, id_memwrite_i;
    logic [3:0]  id_aluop_i;
    logic [2:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [15:0] id_rdata1_i, id_rdata2_i, id_imm_i;
    logic [2:0]  exmem_rd_i, memwb_rd_i;
    logic        exmem_regwrite_i, exmem_memread_i, memwb_regwrite_i;
    logic [15:0] exmem_result_i, memwb_data_i;
    logic        flush_i, hold_i;
    logic        stall_o, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o;
    logic [3:0]  ex_aluop_o;
    logic [15:0] ex_opa_o, ex_opb_o, ex_stdata_o;
    logic [2:0]  ex_rd_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, use_imm;
        logic [3:0]  aluop;
        logic [2:0]  rs1, rs2, rd;
        logic [15:0] rdata1, rdata2, imm;
    } ex_t;
    ex_t m;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_aluop_i(id_aluop_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rd_i(id_rd_i), .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i),
        .id_use_imm_i(id_use_imm_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .id_memwrite_i(id_memwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
        .exmem_memread_i(exmem_memread_i), .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_data_i(memwb_data_i), .flush_i(flush_i),
        .hold_i(hold_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o),
        .ex_opa_o(ex_opa_o), .ex_opb_o(ex_opb_o), .ex_stdata_o(ex_stdata_o), .ex_rd_o(ex_rd_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Does the instruction in ID read register r?
    function automatic bit reads(input logic [2:0] r);
        return id_valid_i && (id_rs1_i == r || (id_rs2_i == r && (!id_use_imm_i || id_memwrite_i)));
    endfunction

    function automatic bit exp_hazard();
        bit hz;
        if (BYP) hz = m.valid && m.memread && reads(m.rd);
        else     hz = (m.valid && m.regwrite && reads(m.rd)) || (exmem_regwrite_i && reads(exmem_rd_i));
        return hz && !flush_i;
    endfunction

    // Value of a source register as the ALU should see it: newest producer that has data.
    function automatic logic [15:0] pick(input logic [2:0] src, input logic [15:0] rf);
        if (BYP && m.valid) begin
            if (exmem_regwrite_i && !exmem_memread_i && exmem_rd_i == src) return exmem_result_i;
            if (memwb_regwrite_i && memwb_rd_i == src) return memwb_data_i;
        end
        return rf;
    endfunction

    task automatic tick();
        bit hz;
        logic [15:0] st;
        hz = exp_hazard();
        st = pick(m.rs2, m.rdata2);
        chk("stall", 16'(stall_o), 16'(hz || hold_i));
        chk("valid", 16'(ex_valid_o), 16'(m.valid));
        chk("regwrite", 16'(ex_regwrite_o), 16'(m.regwrite));
        chk("memread", 16'(ex_memread_o), 16'(m.memread));
        chk("memwrite", 16'(ex_memwrite_o), 16'(m.memwrite));
        chk("aluop", 16'(ex_aluop_o), 16'(m.aluop));
        chk("rd", 16'(ex_rd_o), 16'(m.rd));
        chk("opa", ex_opa_o, pick(m.rs1, m.rdata1));
        chk("stdata", ex_stdata_o, st);
        chk("opb", ex_opb_o, m.use_imm ? m.imm : st);
        if (rst) begin
            m = '0;
        end else if (flush_i || (!hold_i && hz)) begin
            m.valid = 1'b0; m.regwrite = 1'b0; m.memread = 1'b0; m.memwrite = 1'b0;
        end else if (!hold_i) begin
            m = '{id_valid_i, id_regwrite_i & id_valid_i, id_memread_i & id_valid_i,
                  id_memwrite_i & id_valid_i, id_use_imm_i, id_aluop_i, id_rs1_i, id_rs2_i,
                  id_rd_i, id_rdata1_i, id_rdata2_i, id_imm_i};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic id_set(input bit v, input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic [15:0] da, input logic [15:0] db,
                          input bit rw, input bit mr);
        id_valid_i = v; id_aluop_i = op; id_rs1_i = a; id_rs2_i = b; id_rd_i = d;
        id_rdata1_i = da; id_rdata2_i = db; id_imm_i = 16'h0000; id_use_imm_i = 1'b0;
        id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = 1'b0;
    endtask

    task automatic dn_set(input logic [2:0] er, input bit erw, input bit emr, input logic [15:0] eres,
                          input logic [2:0] wr, input bit wrw, input logic [15:0] wd);
        exmem_rd_i = er; exmem_regwrite_i = erw; exmem_memread_i = emr; exmem_result_i = eres;
        memwb_rd_i = wr; memwb_regwrite_i = wrw; memwb_data_i = wd;
    endtask

    task automatic quiet();
        id_set(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        dn_set(3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000);
        flush_i = 1'b0; hold_i = 1'b0; rst = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m = '0;
        rst = 1'b0;
        #1;
        chk("reset_valid", 16'(ex_valid_o), 16'h0000);
        chk("reset_opa", ex_opa_o, 16'h0000);
        tick();

        // Dependent pair: ADD r1 <- r2+r3, then SUB r4 <- r1-r2
        id_set(1'b1, 4'h3, 3'd2, 3'd3, 3'd1, 16'h0005, 16'h0003, 1'b1, 1'b0); #1; tick();
        id_set(1'b1, 4'h4, 3'd1, 3'd2, 3'd4, 16'h0000, 16'h0005, 1'b1, 1'b0); #1;
`ifdef BYPASS_EN
        chk("dep_nostall", 16'(stall_o), 16'h0000); tick();
        id_set(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        dn_set(3'd1, 1'b1, 1'b0, 16'h0008, 3'd0, 1'b0, 16'h0000); #1;
        chk("dep_opa_exmem", ex_opa_o, 16'h0008); tick();
`else
        chk("nb_stall1", 16'(stall_o), 16'h0001); tick();
        dn_set(3'd1, 1'b1, 1'b0, 16'h0008, 3'd0, 1'b0, 16'h0000); #1;
        chk("nb_stall2", 16'(stall_o), 16'h0001); tick();
        dn_set(3'd0, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b1, 16'h0008);
        id_set(1'b1, 4'h4, 3'd1, 3'd2, 3'd4, 16'h0008, 16'h0005, 1'b1, 1'b0); #1;
        chk("nb_release", 16'(stall_o), 16'h0000); tick();
        quiet(); #1;
        chk("nb_opa_rf", ex_opa_o, 16'h0008); tick();
`endif

        // Distance-2: r1 produced earlier, ADD r7 <- r1+r2 now in EX
        quiet();
        id_set(1'b1, 4'h3, 3'd1, 3'd2, 3'd7, 16'h0000, 16'h0002, 1'b1, 1'b0); #1; tick();
        quiet();
        dn_set(3'd2, 1'b1, 1'b0, 16'h7777, 3'd1, 1'b1, 16'h1234); #1;
        chk("d2_memwb", ex_opa_o, BYP ? 16'h1234 : 16'h0000);
        dn_set(3'd1, 1'b1, 1'b0, 16'h5678, 3'd1, 1'b1, 16'h1234); #1;
        chk("d2_exmem_wins", ex_opa_o, BYP ? 16'h5678 : 16'h0000); tick();

        // Load-use: LD r5, then ADD r6 <- r5+r1
        quiet();
        id_set(1'b1, 4'h3, 3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000, 1'b1, 1'b1); #1; tick();
        id_set(1'b1, 4'h3, 3'd5, 3'd1, 3'd6, 16'h0000, 16'h0011, 1'b1, 1'b0); #1;
        chk("lu_stall", 16'(stall_o), 16'h0001); tick();
        dn_set(3'd5, 1'b1, 1'b1, 16'hDEAD, 3'd0, 1'b0, 16'h0000); #1;
        chk("lu_bubble", 16'(ex_valid_o), 16'h0000);
`ifdef BYPASS_EN
        chk("lu_stall_once", 16'(stall_o), 16'h0000); tick();
        id_set(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        dn_set(3'd0, 1'b0, 1'b0, 16'h0000, 3'd5, 1'b1, 16'hBEEF); #1;
        chk("lu_opa_memwb", ex_opa_o, 16'hBEEF); tick();
`else
        chk("lu_nb_stall2", 16'(stall_o), 16'h0001); tick();
        dn_set(3'd0, 1'b0, 1'b0, 16'h0000, 3'd5, 1'b1, 16'hBEEF);
        id_set(1'b1, 4'h3, 3'd5, 3'd1, 3'd6, 16'hBEEF, 16'h0011, 1'b1, 1'b0); #1; tick();
        quiet(); #1;
        chk("lu_nb_opa", ex_opa_o, 16'hBEEF); tick();
`endif

        // Reset arriving during a load-use stall
        quiet();
        id_set(1'b1, 4'h3, 3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000, 1'b1, 1'b1); #1; tick();
        id_set(1'b1, 4'h3, 3'd5, 3'd1, 3'd6, 16'h0000, 16'h0011, 1'b1, 1'b0);
        rst = 1'b1; #1;
        chk("rst_stall_pre", 16'(stall_o), 16'h0001); tick();
        rst = 1'b0; #1;
        chk("rst_valid", 16'(ex_valid_o), 16'h0000);
        chk("rst_regwrite", 16'(ex_regwrite_o), 16'h0000);
        chk("rst_stall", 16'(stall_o), 16'h0000); tick();

        // Flush and hold in the same cycle
        quiet();
        id_set(1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 16'h00AA, 16'h0055, 1'b1, 1'b0); #1; tick();
        flush_i = 1'b1; hold_i = 1'b1; #1; tick();
        quiet(); #1;
        chk("flush_valid", 16'(ex_valid_o), 16'h0000);
        chk("flush_regwrite", 16'(ex_regwrite_o), 16'h0000); tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(49) == 0);
            flush_i = ($urandom_range(7) == 0);
            hold_i = ($urandom_range(5) == 0);
            id_valid_i = 1'($urandom); id_aluop_i = 4'($urandom_range(7));
            id_rs1_i = 3'($urandom); id_rs2_i = 3'($urandom); id_rd_i = 3'($urandom);
            id_rdata1_i = 16'($urandom); id_rdata2_i = 16'($urandom); id_imm_i = 16'($urandom);
            id_use_imm_i = 1'($urandom); id_regwrite_i = 1'($urandom);
            id_memread_i = ($urandom_range(2) == 0); id_memwrite_i = ($urandom_range(3) == 0);
            dn_set(3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                   3'($urandom), 1'($urandom), 16'($urandom));
            #1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
